// File: rtl/vx_alu_batch_pkg.sv
// Shared types for the batched ALU execute unit.
//   XLEN      : datapath width
//   alu_op_e  : ALU operation encoding
//   br_op_e   : branch operation encoding
//   state_e   : sequencing FSM states
package vx_alu_batch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_JAL  = 3'd6,
    BR_JALR = 3'd7
  } br_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vx_alu_batch_unit_if.sv
// Request / commit / branch-resolution bundle of the batched ALU unit.
//   req_* : warp-wide ALU/branch request (valid/ready)
//   cmt_* : per-request commit with per-thread data (valid/ready)
//   br_*  : branch resolution, reported alongside the commit handshake
// master = request producer / commit consumer, slave = the ALU unit.
interface vx_alu_batch_unit_if
  import vx_alu_batch_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned WID_W       = 2,
  parameter int unsigned NR_W        = 5
);
  localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  logic                        req_valid;
  logic                        req_ready;
  logic [WID_W-1:0]            req_wid;
  logic [NUM_THREADS-1:0]      req_tmask;
  logic [XLEN-1:0]             req_pc;
  logic [XLEN-1:0]             req_next_pc;
  logic [NR_W-1:0]             req_rd;
  logic                        req_wb;
  alu_op_e                     req_op;
  logic                        req_is_br;
  br_op_e                      req_br_op;
  logic                        req_use_pc;
  logic                        req_use_imm;
  logic [XLEN-1:0]             req_imm;
  logic [TID_W-1:0]            req_tid;
  logic [NUM_THREADS*XLEN-1:0] req_rs1;
  logic [NUM_THREADS*XLEN-1:0] req_rs2;

  logic                        cmt_valid;
  logic                        cmt_ready;
  logic [WID_W-1:0]            cmt_wid;
  logic [NUM_THREADS-1:0]      cmt_tmask;
  logic [XLEN-1:0]             cmt_pc;
  logic [NR_W-1:0]             cmt_rd;
  logic                        cmt_wb;
  logic [NUM_THREADS*XLEN-1:0] cmt_data;

  logic                        br_valid;
  logic                        br_taken;
  logic [WID_W-1:0]            br_wid;
  logic [XLEN-1:0]             br_dest;

  modport master (
    output req_valid, req_wid, req_tmask, req_pc, req_next_pc, req_rd, req_wb,
           req_op, req_is_br, req_br_op, req_use_pc, req_use_imm, req_imm,
           req_tid, req_rs1, req_rs2, cmt_ready,
    input  req_ready, cmt_valid, cmt_wid, cmt_tmask, cmt_pc, cmt_rd, cmt_wb,
           cmt_data, br_valid, br_taken, br_wid, br_dest
  );

  modport slave (
    input  req_valid, req_wid, req_tmask, req_pc, req_next_pc, req_rd, req_wb,
           req_op, req_is_br, req_br_op, req_use_pc, req_use_imm, req_imm,
           req_tid, req_rs1, req_rs2, cmt_ready,
    output req_ready, cmt_valid, cmt_wid, cmt_tmask, cmt_pc, cmt_rd, cmt_wb,
           cmt_data, br_valid, br_taken, br_wid, br_dest
  );

endinterface

// File: rtl/vx_alu_lane.sv
// Combinational single-thread 32-bit integer ALU.
//   op     : operation select
//   in1    : first operand
//   in2    : second operand (in2[4:0] is the shift amount)
//   result : operation result (0 for unused encodings)
module vx_alu_lane
  import vx_alu_batch_pkg::*;
(
  input  alu_op_e         op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = in1 + in2;
      OP_SUB:  result = in1 - in2;
      OP_SLL:  result = in1 << in2[4:0];
      OP_SLT:  result = XLEN'($signed(in1) < $signed(in2));
      OP_SLTU: result = XLEN'(in1 < in2);
      OP_XOR:  result = in1 ^ in2;
      OP_SRL:  result = in1 >> in2[4:0];
      OP_SRA:  result = $unsigned($signed(in1) >>> in2[4:0]);
      OP_OR:   result = in1 | in2;
      OP_AND:  result = in1 & in2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vx_alu_batch_unit.sv
// Warp-wide integer ALU: executes a request on NUM_LANES lanes, one thread
// batch per cycle, skipping empty batches, and commits once per request.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : request / commit / branch-resolution bundle (slave side)
module vx_alu_batch_unit
  import vx_alu_batch_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned WID_W       = 2,
  parameter int unsigned NR_W        = 5,
  parameter int unsigned SKIP_EMPTY  = 1
) (
  input  logic                clk,
  input  logic                reset,
  vx_alu_batch_unit_if.slave  bus
);

  localparam int unsigned NB     = NUM_THREADS / NUM_LANES;
  localparam int unsigned BIDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned TID_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  state_e                 state_q, state_d;
  logic [BIDX_W-1:0]      batch_q, batch_d;
  logic [WID_W-1:0]       wid_q, wid_d;
  logic [NUM_THREADS-1:0] tmask_q, tmask_d;
  logic [XLEN-1:0]        pc_q, pc_d, next_pc_q, next_pc_d, br_dest_q, br_dest_d;
  logic [NR_W-1:0]        rd_q, rd_d;
  logic                   wb_q, wb_d, is_br_q, is_br_d, jump_q, jump_d;
  logic                   br_taken_q, br_taken_d;
  alu_op_e                op_q, op_d;
  // Operand muxing is resolved at accept, so only the selected operands are held.
  logic [XLEN-1:0]        in1_q [NUM_THREADS];
  logic [XLEN-1:0]        in1_d [NUM_THREADS];
  logic [XLEN-1:0]        in2_q [NUM_THREADS];
  logic [XLEN-1:0]        in2_d [NUM_THREADS];
  logic [XLEN-1:0]        res_q [NUM_THREADS];
  logic [XLEN-1:0]        res_d [NUM_THREADS];

  logic [XLEN-1:0]        rs1_in [NUM_THREADS];
  logic [XLEN-1:0]        rs2_in [NUM_THREADS];
  logic [NB-1:0]          qual_req, qual_lat;
  logic                   first_found, next_found;
  logic [BIDX_W-1:0]      first_idx, next_idx;
  logic [TID_W-1:0]       lane_tid [NUM_LANES];
  logic [XLEN-1:0]        lane_res [NUM_LANES];
  logic [XLEN-1:0]        br_a, br_b, br_dest_calc;
  logic                   br_cond, req_ready, accept;
  logic [NUM_THREADS*XLEN-1:0] cmt_data_flat;

  // Batch qualification and next-qualifying-batch priority encoders: one scan
  // of the incoming mask (first batch at accept) and one of the latched mask
  // (strictly after the batch currently executing).
  always_comb begin
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      rs1_in[t] = bus.req_rs1[t*XLEN +: XLEN];
      rs2_in[t] = bus.req_rs2[t*XLEN +: XLEN];
    end
    for (int unsigned b = 0; b < NB; b++) begin
      qual_req[b] = (SKIP_EMPTY == 0) || (|bus.req_tmask[b*NUM_LANES +: NUM_LANES]);
      qual_lat[b] = (SKIP_EMPTY == 0) || (|tmask_q[b*NUM_LANES +: NUM_LANES]);
    end
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (qual_req[b] && !first_found) begin
        first_found = 1'b1;
        first_idx   = BIDX_W'(b);
      end
      if (qual_lat[b] && !next_found && (b > 32'(batch_q))) begin
        next_found = 1'b1;
        next_idx   = BIDX_W'(b);
      end
    end
    for (int unsigned j = 0; j < NUM_LANES; j++) begin
      lane_tid[j] = TID_W'(32'(batch_q) * NUM_LANES + j);
    end
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    vx_alu_lane u_lane (
      .op     (op_q),
      .in1    (in1_q[lane_tid[j]]),
      .in2    (in2_q[lane_tid[j]]),
      .result (lane_res[j])
    );
  end

  // Branch resolution uses the raw rs1/rs2 of the selected thread.
  always_comb begin
    br_a = rs1_in[bus.req_tid];
    br_b = rs2_in[bus.req_tid];
    case (bus.req_br_op)
      BR_BEQ:  br_cond = (br_a == br_b);
      BR_BNE:  br_cond = (br_a != br_b);
      BR_BLT:  br_cond = ($signed(br_a) < $signed(br_b));
      BR_BGE:  br_cond = ($signed(br_a) >= $signed(br_b));
      BR_BLTU: br_cond = (br_a < br_b);
      BR_BGEU: br_cond = (br_a >= br_b);
      default: br_cond = 1'b1;
    endcase
    br_dest_calc = (bus.req_use_pc ? bus.req_pc : br_a) + bus.req_imm;
  end

  always_comb begin
    state_d    = state_q;
    batch_d    = batch_q;
    wid_d      = wid_q;
    tmask_d    = tmask_q;
    pc_d       = pc_q;
    next_pc_d  = next_pc_q;
    rd_d       = rd_q;
    wb_d       = wb_q;
    op_d       = op_q;
    is_br_d    = is_br_q;
    jump_d     = jump_q;
    br_taken_d = br_taken_q;
    br_dest_d  = br_dest_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    res_d      = res_q;

    req_ready = reset && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.cmt_ready));
    accept    = bus.req_valid && req_ready;

    case (state_q)
      ST_EXEC: begin
        for (int unsigned j = 0; j < NUM_LANES; j++) begin
          if (tmask_q[lane_tid[j]]) res_d[lane_tid[j]] = jump_q ? next_pc_q : lane_res[j];
        end
        if (next_found) batch_d = next_idx;
        else            state_d = ST_DONE;
      end
      ST_DONE: if (bus.cmt_ready) state_d = ST_IDLE;
      default: ;
    endcase

    // Accept may coincide with the DONE commit; it overrides the IDLE return.
    if (accept) begin
      wid_d      = bus.req_wid;
      tmask_d    = bus.req_tmask;
      pc_d       = bus.req_pc;
      next_pc_d  = bus.req_next_pc;
      rd_d       = bus.req_rd;
      wb_d       = bus.req_wb;
      op_d       = bus.req_op;
      is_br_d    = bus.req_is_br;
      jump_d     = bus.req_is_br && ((bus.req_br_op == BR_JAL) || (bus.req_br_op == BR_JALR));
      br_taken_d = br_cond;
      br_dest_d  = br_dest_calc;
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        in1_d[t] = bus.req_use_pc  ? bus.req_pc  : rs1_in[t];
        in2_d[t] = bus.req_use_imm ? bus.req_imm : rs2_in[t];
        res_d[t] = '0;
      end
      batch_d = first_idx;
      state_d = first_found ? ST_EXEC : ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      batch_q    <= '0;
      wid_q      <= '0;
      tmask_q    <= '0;
      pc_q       <= '0;
      next_pc_q  <= '0;
      rd_q       <= '0;
      wb_q       <= 1'b0;
      op_q       <= OP_ADD;
      is_br_q    <= 1'b0;
      jump_q     <= 1'b0;
      br_taken_q <= 1'b0;
      br_dest_q  <= '0;
      in1_q      <= '{default: '0};
      in2_q      <= '{default: '0};
      res_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      batch_q    <= batch_d;
      wid_q      <= wid_d;
      tmask_q    <= tmask_d;
      pc_q       <= pc_d;
      next_pc_q  <= next_pc_d;
      rd_q       <= rd_d;
      wb_q       <= wb_d;
      op_q       <= op_d;
      is_br_q    <= is_br_d;
      jump_q     <= jump_d;
      br_taken_q <= br_taken_d;
      br_dest_q  <= br_dest_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      res_q      <= res_d;
    end
  end

  always_comb begin
    for (int unsigned t = 0; t < NUM_THREADS; t++) cmt_data_flat[t*XLEN +: XLEN] = res_q[t];
  end

  assign bus.req_ready = req_ready;
  assign bus.cmt_valid = (state_q == ST_DONE);
  assign bus.cmt_wid   = wid_q;
  assign bus.cmt_tmask = tmask_q;
  assign bus.cmt_pc    = pc_q;
  assign bus.cmt_rd    = rd_q;
  assign bus.cmt_wb    = wb_q;
  assign bus.cmt_data  = cmt_data_flat;
  assign bus.br_valid  = (state_q == ST_DONE) && bus.cmt_ready && is_br_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.br_wid    = wid_q;
  assign bus.br_dest   = br_dest_q;

endmodule
